memc_deskew: RTL and testbench
==============================

Name: memc_deskew

Overview:
- Output-side counterpart to the A-operand skew buffer of the systolic MAC array.
- The array drains results skewed along the diagonal: column lane j presents row r's result on capture beat r+j. This block collects one full DIM x DIM result tile and realigns it into rows.
- After capture it offers row-addressed reads, one full row per read.
- Sits between the systolic array outputs and the host/result-readout logic.

Parameters:
- BITS_C, 16, signed width of each result element.
- DIM, 8, array dimension (lanes, rows, columns).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a new tile capture.
- in_valid  input  1  Cin holds a valid capture beat.
- Cin  input  signed [BITS_C-1:0] x [DIM]  skewed result lanes from the array, lane j = column j.
- rd_en  input  1  read request.
- Crow  input  [$clog2(DIM)-1:0]  row to read.
- Cout  output  signed [BITS_C-1:0] x [DIM]  registered row data.
- out_valid  output  1  Cout updated this cycle (one-cycle pulse).
- busy  output  1  capture in progress.
- ready  output  1  complete tile held, reads allowed.

Behaviour:
- Reset (synchronous, rst_n low at posedge): state IDLE, beat counter 0, storage all 0, Cout all 0, out_valid 0, busy 0, ready 0. Reset mid-capture aborts and discards the partial tile.
- States are IDLE, CAPTURE and READY. busy = (state==CAPTURE). ready = (state==READY). Both are registered.
- start sampled in IDLE or READY:
  - Next cycle: all storage cleared to 0, counter 0, state CAPTURE.
  - Cin on the start cycle is ignored.
- CAPTURE, in_valid high, counter value t:
  - For each lane j, with r = t - j: if 0 <= r <= DIM-1, store[r][j] <= Cin[j]; otherwise lane j is discarded.
  - Counter increments.
  - If t == 2*DIM-2, state goes to READY next cycle.
  - A tile therefore needs exactly 2*DIM-1 valid beats.
- CAPTURE, in_valid low: stall. Counter and storage hold; no timeout.
- start during CAPTURE is ignored.
- in_valid outside CAPTURE is ignored.
- Reads:
  - rd_en in READY: next cycle Cout[j] = store[Crow][j] for all j, out_valid = 1 for one cycle. Latency 1.
  - Back-to-back reads are allowed, one per cycle. ready stays high; tiles may be reread indefinitely.
  - Crow >= DIM (non-power-of-2 DIM): Cout all 0, out_valid 1.
  - rd_en outside READY: ignored. out_valid 0, Cout holds its last value.
- rd_en and start in the same READY cycle: the read returns pre-clear contents (out_valid 1); the clear and transition to CAPTURE still occur.
- Element arithmetic: none. Values are stored and returned bit-exact, with sign preserved.

Optional Feature:
- Macro: MEMC_DESKEW_ERR_EN.
- Defined:
  - Adds output port err (1 bit, reset 0, sticky).
  - err is set on: start during CAPTURE, in_valid outside CAPTURE, or rd_en outside READY.
  - err is cleared only by reset or by an accepted start.
- Undefined: no err port, no error logic. These events are silently ignored as described above.

Test Plan:
- Reset: hold rst_n low 2 cycles with random inputs -> Cout all 0, out_valid, busy and ready all 0. rd_en Crow=0 afterwards -> out_valid stays 0.
- Full capture (DIM=8, BITS_C=16):
  - Stimulus: start, then 15 consecutive valid beats. Lane j carries 16*r+j when r=t-j is in range, else 16'hDEAD.
  - Response: busy high for 15 cycles, then ready=1.
  - rd_en Crow=3 -> next cycle Cout[j]=48+j, out_valid pulse. Crow=7 -> Cout[j]=112+j. No 16'hDEAD anywhere.
- Stall: same data as full capture, with in_valid low for 3 cycles after beat 5 -> identical readout; ready rises 3 cycles later than unstalled.
- Negative values: lane data = -(16*r+j) -> Cout row 2 reads -(32+j) with correct sign.
- Illegal/overlap events:
  - start at beat 7 of capture -> ignored; capture completes normally after beat 14.
  - With MEMC_DESKEW_ERR_EN: err=1 after that start and stays 1 until the next accepted start.
  - Same-cycle rd_en + start in READY -> old row returned, busy=1 next cycle.
- Reset mid-capture after beat 7 -> ready 0, busy 0. New start plus 15 beats of value 5 -> every row reads all 5.

Source files
------------

// File: rtl/memc_deskew.sv
// memc_deskew: collects one diagonally skewed DIM x DIM result tile from the
// systolic array and offers row-addressed reads of the realigned tile.
// Column lane j carries row r's result on capture beat r+j.
// Optional build macro MEMC_DESKEW_ERR_EN adds a sticky err output.
module memc_deskew #(
  parameter int unsigned BITS_C = 16,
  parameter int unsigned DIM    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [BITS_C-1:0] Cin [DIM],
  input  logic                     rd_en,
  input  logic [$clog2(DIM)-1:0]   Crow,
  output logic signed [BITS_C-1:0] Cout [DIM],
  output logic                     out_valid,
  output logic                     busy,
`ifdef MEMC_DESKEW_ERR_EN
  output logic                     err,
`endif
  output logic                     ready
);

  // Beat counter spans 0 .. 2*DIM-2.
  localparam int unsigned   CntW     = $clog2(2 * DIM);
  localparam logic [CntW-1:0] LastBeat = CntW'(2 * DIM - 2);

  typedef enum logic [1:0] {StIdle, StCapture, StReady} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic signed [BITS_C-1:0] store_q [DIM][DIM];
  logic                     clear;
  logic                     beat;
  logic                     rd_acc;
  logic                     wr_en [DIM][DIM];

  // Next-state, counter and capture/clear strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    beat    = 1'b0;
    case (state_q)
      StIdle, StReady: begin
        if (start) begin
          clear   = 1'b1;
          cnt_d   = '0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (in_valid) begin
          beat  = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastBeat) begin
            state_d = StReady;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_acc = rd_en && (state_q == StReady);

  // Element (r, j) is captured on the beat where counter == r + j; other lanes are dropped.
  always_comb begin
    for (int r = 0; r < int'(DIM); r++) begin
      for (int j = 0; j < int'(DIM); j++) begin
        wr_en[r][j] = beat && (cnt_q == CntW'(r + j));
      end
    end
  end

  // FSM state, beat counter and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d == StCapture);
      ready   <= (state_d == StReady);
    end
  end

  // Tile storage: cleared on reset or accepted start, written on capture beats.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int r = 0; r < int'(DIM); r++) begin
        for (int j = 0; j < int'(DIM); j++) begin
          store_q[r][j] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < int'(DIM); r++) begin
        for (int j = 0; j < int'(DIM); j++) begin
          if (wr_en[r][j]) begin
            store_q[r][j] <= Cin[j];
          end
        end
      end
    end
  end

  // Row read port; reads the pre-clear contents when a start coincides with the read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      for (int j = 0; j < int'(DIM); j++) begin
        Cout[j] <= '0;
      end
    end else begin
      out_valid <= rd_acc;
      if (rd_acc) begin
        for (int j = 0; j < int'(DIM); j++) begin
          Cout[j] <= (32'(Crow) < DIM) ? store_q[Crow][j] : '0;
        end
      end
    end
  end

`ifdef MEMC_DESKEW_ERR_EN
  logic err_q;

  // Sticky protocol-violation flag; an accepted start wipes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (clear) begin
      err_q <= 1'b0;
    end else if ((start && (state_q == StCapture)) ||
                 (in_valid && (state_q != StCapture)) ||
                 (rd_en && (state_q != StReady))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_memc_deskew.sv
// Self-checking bench for memc_deskew: skewed tile capture, stalls, row reads,
// overlap events and resets, checked against an intended-tile reference model.
module tb_memc_deskew;

  localparam int DIM    = 8;
  localparam int BITS_C = 16;
  localparam int BEATS  = 2 * DIM - 1;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic                     in_valid;
  logic signed [BITS_C-1:0] Cin [DIM];
  logic                     rd_en;
  logic [2:0]               Crow;
  logic signed [BITS_C-1:0] Cout [DIM];
  logic                     out_valid;
  logic                     busy;
  logic                     ready;
`ifdef MEMC_DESKEW_ERR_EN
  logic                     err;
`endif

  int errors = 0;
  int checks = 0;

  // Intended tile being sent, and what a completed capture should hold.
  logic signed [BITS_C-1:0] tile [DIM][DIM];
  logic signed [BITS_C-1:0] model_store [DIM][DIM];
  bit garb_rand = 1'b0;

  memc_deskew #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .Cin       (Cin),
    .rd_en     (rd_en),
    .Crow      (Crow),
    .Cout      (Cout),
    .out_valid (out_valid),
    .busy      (busy),
`ifdef MEMC_DESKEW_ERR_EN
    .err       (err),
`endif
    .ready     (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cin();
    for (int j = 0; j < DIM; j++) Cin[j] = BITS_C'($urandom);
  endtask

  task automatic read_row(input int row);
    rd_en = 1'b1;
    Crow  = 3'(row);
    tick();
    rd_en = 1'b0;
  endtask

  // Drives a skewed tile: optional start pulse, 15 valid beats with an optional
  // stall, optional illegal start and optional abort. cyc counts cycles after start.
  task automatic run_capture(input bit do_start, input int stall_at, input int stall_len,
                             input int start_at, input int abort_at,
                             output int cyc, output bit busy_ok);
    if (do_start) begin
      start    = 1'b1;
      in_valid = 1'($urandom);
      rand_cin();
      tick();
      start = 1'b0;
    end
    busy_ok = 1'b1;
    cyc     = 0;
    for (int t = 0; t < BEATS; t++) begin
      if (t == abort_at) break;
      if (t == stall_at) begin
        repeat (stall_len) begin
          in_valid = 1'b0;
          rand_cin();
          tick();
          cyc++;
          if (busy !== 1'b1 || ready !== 1'b0) busy_ok = 1'b0;
        end
      end
      in_valid = 1'b1;
      start    = (t == start_at);
      for (int j = 0; j < DIM; j++) begin
        if (t - j >= 0 && t - j < DIM) Cin[j] = tile[t-j][j];
        else Cin[j] = garb_rand ? BITS_C'($urandom) : 16'hDEAD;
      end
      tick();
      cyc++;
      start = 1'b0;
      if (t < BEATS - 1 && (busy !== 1'b1 || ready !== 1'b0)) busy_ok = 1'b0;
    end
    in_valid = 1'b0;
    if (abort_at < 0) begin
      for (int r = 0; r < DIM; r++)
        for (int j = 0; j < DIM; j++) model_store[r][j] = tile[r][j];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      rd_en    = 1'($urandom);
      Crow     = 3'($urandom);
      rand_cin();
      tick();
    end
    start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (Cout[j] !== 16'sd0) begin
        errors++;
        $display("FAIL reset_cout lane %0d: got %0d want 0", j, Cout[j]);
      end
    end
    checks++;
    if ({out_valid, busy, ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got ov/busy/ready=%b want 000", {out_valid, busy, ready});
    end
`ifdef MEMC_DESKEW_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", err);
    end
`endif
    rst_n = 1'b1;
    read_row(0);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_read: got ov/busy/ready=%b%b%b want 000", out_valid, busy, ready);
    end
`ifdef MEMC_DESKEW_ERR_EN
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_idle_valid: got %b want 1", err);
    end
`endif
  endtask

  task automatic test_full_capture();
    int cyc;
    bit ok;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) tile[r][j] = BITS_C'(16 * r + j);
    garb_rand = 1'b0;
    run_capture(1'b1, -1, 0, -1, -1, cyc, ok);
    checks++;
    if (!ok || ready !== 1'b1 || busy !== 1'b0 || cyc != BEATS) begin
      errors++;
      $display("FAIL full_timing: got ok=%0d ready=%b busy=%b cyc=%0d want 1 1 0 %0d",
               ok, ready, busy, cyc, BEATS);
    end
`ifdef MEMC_DESKEW_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared_by_start: got %b want 0", err);
    end
`endif
    read_row(3);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_row3_valid: got %b want 1", out_valid);
    end
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (Cout[j] !== BITS_C'(48 + j)) begin
        errors++;
        $display("FAIL full_row3 lane %0d: got %h want %h", j, Cout[j], BITS_C'(48 + j));
      end
    end
    read_row(7);
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (Cout[j] !== BITS_C'(112 + j)) begin
        errors++;
        $display("FAIL full_row7 lane %0d: got %h want %h", j, Cout[j], BITS_C'(112 + j));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pulse: got ov=%b ready=%b want 0 1", out_valid, ready);
    end
  endtask

  task automatic test_stall();
    int cyc;
    bit ok;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) tile[r][j] = BITS_C'(16 * r + j);
    garb_rand = 1'b0;
    run_capture(1'b1, 6, 3, -1, -1, cyc, ok);
    checks++;
    if (!ok || ready !== 1'b1 || cyc != BEATS + 3) begin
      errors++;
      $display("FAIL stall_timing: got ok=%0d ready=%b cyc=%0d want 1 1 %0d",
               ok, ready, cyc, BEATS + 3);
    end
    // Back-to-back reads of every row.
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_valid row %0d: got %b want 1", r, out_valid);
      end
      for (int j = 0; j < DIM; j++) begin
        checks++;
        if (Cout[j] !== BITS_C'(16 * r + j)) begin
          errors++;
          $display("FAIL stall_row %0d lane %0d: got %h want %h", r, j, Cout[j],
                   BITS_C'(16 * r + j));
        end
      end
    end
  endtask

  task automatic test_negative();
    int cyc;
    bit ok;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) tile[r][j] = BITS_C'(-(16 * r + j));
    garb_rand = 1'b1;
    run_capture(1'b1, -1, 0, -1, -1, cyc, ok);
    read_row(2);
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (Cout[j] !== BITS_C'(-(32 + j)) || $signed(Cout[j]) >= 0) begin
        errors++;
        $display("FAIL neg_row2 lane %0d: got %0d want %0d", j, $signed(Cout[j]), -(32 + j));
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    bit ok;
    int row;
    garb_rand = 1'b1;
    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < DIM; r++)
        for (int j = 0; j < DIM; j++) tile[r][j] = BITS_C'($urandom);
      run_capture(1'b1, int'($urandom_range(0, BEATS - 1)), int'($urandom_range(0, 4)),
                  -1, -1, cyc, ok);
      checks++;
      if (!ok || ready !== 1'b1) begin
        errors++;
        $display("FAIL rand_ready iter %0d: got ok=%0d ready=%b want 1 1", it, ok, ready);
      end
      for (int k = 0; k < DIM; k++) begin
        row = int'($urandom_range(0, DIM - 1));
        read_row(row);
        for (int j = 0; j < DIM; j++) begin
          checks++;
          if (out_valid !== 1'b1 || Cout[j] !== model_store[row][j]) begin
            errors++;
            $display("FAIL rand_row %0d lane %0d: got ov=%b %h want 1 %h", row, j,
                     out_valid, Cout[j], model_store[row][j]);
          end
        end
      end
    end
  endtask

  task automatic test_start_during_capture();
    int cyc;
    bit ok;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) tile[r][j] = BITS_C'(16 * r + j);
    garb_rand = 1'b0;
    run_capture(1'b1, -1, 0, 7, -1, cyc, ok);
    checks++;
    if (!ok || ready !== 1'b1 || cyc != BEATS) begin
      errors++;
      $display("FAIL overlap_start: got ok=%0d ready=%b cyc=%0d want 1 1 %0d",
               ok, ready, cyc, BEATS);
    end
`ifdef MEMC_DESKEW_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_overlap_start: got %b want 1", err);
    end
`endif
    read_row(5);
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (Cout[j] !== BITS_C'(80 + j)) begin
        errors++;
        $display("FAIL overlap_row5 lane %0d: got %h want %h", j, Cout[j], BITS_C'(80 + j));
      end
    end
  endtask

  task automatic test_rd_start_same();
    int cyc;
    bit ok;
    // Holds tile 16*r+j from the previous test.
    rd_en = 1'b1;
    Crow  = 3'd4;
    start = 1'b1;
    tick();
    rd_en = 1'b0;
    start = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL rdstart_flags: got ov/busy/ready=%b%b%b want 110", out_valid, busy, ready);
    end
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (Cout[j] !== BITS_C'(64 + j)) begin
        errors++;
        $display("FAIL rdstart_row4 lane %0d: got %h want %h", j, Cout[j], BITS_C'(64 + j));
      end
    end
`ifdef MEMC_DESKEW_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_rdstart_clear: got %b want 0", err);
    end
`endif
    // A read during capture is ignored and Cout holds.
    read_row(1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL capture_read_valid: got %b want 0", out_valid);
    end
    for (int j = 0; j < DIM; j++) begin
      checks++;
      if (Cout[j] !== BITS_C'(64 + j)) begin
        errors++;
        $display("FAIL capture_read_hold lane %0d: got %h want %h", j, Cout[j],
                 BITS_C'(64 + j));
      end
    end
`ifdef MEMC_DESKEW_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_capture_read: got %b want 1", err);
    end
`endif
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) tile[r][j] = BITS_C'($urandom);
    garb_rand = 1'b1;
    run_capture(1'b0, -1, 0, -1, -1, cyc, ok);
    checks++;
    if (!ok || ready !== 1'b1) begin
      errors++;
      $display("FAIL rdstart_recapture: got ok=%0d ready=%b want 1 1", ok, ready);
    end
    for (int r = DIM - 1; r >= 0; r--) begin
      read_row(r);
      for (int j = 0; j < DIM; j++) begin
        checks++;
        if (Cout[j] !== model_store[r][j]) begin
          errors++;
          $display("FAIL rdstart_new row %0d lane %0d: got %h want %h", r, j, Cout[j],
                   model_store[r][j]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) tile[r][j] = BITS_C'($urandom);
    run_capture(1'b1, -1, 0, -1, 8, cyc, ok);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: got busy=%b ready=%b want 0 0", busy, ready);
    end
    read_row(0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_read: got %b want 0", out_valid);
    end
    for (int r = 0; r < DIM; r++)
      for (int j = 0; j < DIM; j++) tile[r][j] = 16'sd5;
    garb_rand = 1'b1;
    run_capture(1'b1, -1, 0, -1, -1, cyc, ok);
    for (int r = 0; r < DIM; r++) begin
      read_row(r);
      for (int j = 0; j < DIM; j++) begin
        checks++;
        if (Cout[j] !== 16'sd5 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL midreset_row %0d lane %0d: got ov=%b %0d want 1 5", r, j,
                   out_valid, Cout[j]);
        end
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    Crow     = '0;
    for (int j = 0; j < DIM; j++) Cin[j] = '0;
    test_reset();
    test_full_capture();
    test_stall();
    test_negative();
    test_random();
    test_start_during_capture();
    test_rd_start_same();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
